// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage and a variable-latency memory.
// The MEM stage is the master; the memory (or a bench model of it) is the slave.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 16-bit WISC pipeline. Non-memory instructions pass to the
// MEM/WB register in one cycle. A load or store spends one IDLE cycle latching
// its operands and then waits in BUSY for mem_ready, stalling upstream. An
// access that never completes is force-retired after TIMEOUT BUSY cycles and
// raises a sticky mem_err.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   alu_result_in,
  input  logic [DATA_W-1:0]   dataIn_in,
  input  logic [REG_W-1:0]    dstReg_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                reg_write_in,
  output logic                stall,
  mem_stage_ctrl_if.master    mem_bus,
  output logic [DATA_W-1:0]   wb_data,
  output logic [REG_W-1:0]    wb_dstReg,
  output logic                wb_reg_write,
  output logic                mem_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              we_q, we_d;          // latched op: 1 = store
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  dst_q, dst_d;        // latched destination of a load
  logic              rw_q, rw_d;          // latched register-write of a load
  logic [7:0]        cnt_q, cnt_d;        // BUSY cycles seen without mem_ready
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_dst_q, wb_dst_d;
  logic              wb_rw_q, wb_rw_d;
  logic              err_q, err_d;

  logic mem_op;
  logic busy;
  logic timeout_hit;
  logic done;

  // Decode the current op and the completion conditions of an outstanding access.
  always_comb begin
    mem_op      = in_valid & (mem_read_in | mem_write_in);
    busy        = (state_q == BUSY);
    timeout_hit = busy & ~mem_bus.mem_ready & (cnt_q == TIMEOUT_C - 8'd1);
    done        = busy & (mem_bus.mem_ready | timeout_hit);
    // Completion releases the stall in the same cycle so EX/MEM advances at the edge.
    stall       = busy ? ~done : mem_op;
  end

  // Next-state and next-register values for the stage.
  always_comb begin
    // NOTE: every _d starts as its _q so that no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dst_d     = dst_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_dst_d  = wb_dst_q;
    wb_rw_d   = wb_rw_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          // Capture the access; a request with both bits set is a store.
          state_d = BUSY;
          we_d    = mem_write_in;
          addr_d  = alu_result_in;
          wdata_d = dataIn_in;
          dst_d   = dstReg_in;
          rw_d    = reg_write_in & ~mem_write_in;
          cnt_d   = 8'd0;
          wb_rw_d = 1'b0;   // bubble into writeback while the access runs
        end else begin
          wb_data_d = alu_result_in;
          wb_dst_d  = dstReg_in;
          wb_rw_d   = in_valid & reg_write_in;
        end
      end
      BUSY: begin
        if (!mem_bus.mem_ready && cnt_q != TIMEOUT_C) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          state_d = IDLE;
          if (we_q) begin
            wb_rw_d = 1'b0;
          end else begin
            // A timed-out load retires as data 0 with no register write.
            wb_data_d = timeout_hit ? '0 : mem_bus.mem_rdata;
            wb_dst_d  = dst_q;
            wb_rw_d   = rw_q & ~timeout_hit;
          end
          if (timeout_hit) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dst_q     <= '0;
      rw_q      <= 1'b0;
      cnt_q     <= 8'd0;
      wb_data_q <= '0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dst_q     <= dst_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
      wb_rw_q   <= wb_rw_d;
      err_q     <= err_d;
    end
  end

  // Memory bus comes straight from registers: no input-to-bus combinational path.
  assign mem_bus.mem_req   = busy;
  assign mem_bus.mem_we    = busy & we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;

  assign wb_data      = wb_data_q;
  assign wb_dstReg    = wb_dst_q;
  assign wb_reg_write = wb_rw_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a stimulus process issues instructions like an
// upstream stage honouring stall, a memory responder serves the bus with a
// chosen latency, and a writeback monitor compares each retirement against a
// transaction-level model kept in queues.
module tb_mem_stage_ctrl;
  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int TIMEOUT = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] dataIn_in;
  logic [REG_W-1:0]  dstReg_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              reg_write_in;
  logic              stall;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_dstReg;
  logic              wb_reg_write;
  logic              mem_err;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

  mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .alu_result_in (alu_result_in),
    .dataIn_in     (dataIn_in),
    .dstReg_in     (dstReg_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .reg_write_in  (reg_write_in),
    .stall         (stall),
    .mem_bus       (mem_bus),
    .wb_data       (wb_data),
    .wb_dstReg     (wb_dstReg),
    .wb_reg_write  (wb_reg_write),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dst;
  } wb_exp_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                lat;   // BUSY cycle on which ready comes; 0 = never
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  logic [DATA_W-1:0] ref_mem   [logic [DATA_W-1:0]];  // reference model's memory
  logic [DATA_W-1:0] mem_array [logic [DATA_W-1:0]];  // responder's memory

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_rd(input logic [DATA_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] arr_rd(input logic [DATA_W-1:0] a);
    return mem_array.exists(a) ? mem_array[a] : '0;
  endfunction

  // Present one instruction (called at posedge+1), hold it while stalled and
  // return at posedge+1 after the edge that consumed it.
  task automatic issue(input logic v, input logic rd, input logic wr, input logic rw,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] din,
                       input logic [REG_W-1:0] dst, input int lat);
    wb_exp_t  e;
    bus_exp_t b;
    bit       is_mem;
    int       occ;
    int       exp_occ;
    is_mem = v && (rd || wr);
    e.dst  = dst;
    e.data = alu;
    e.we   = v & rw;
    if (is_mem) begin
      b.we = wr; b.addr = alu; b.wdata = din; b.lat = lat;
      bus_q.push_back(b);
      if (wr) begin
        e.we = 1'b0;
        if (lat != 0) ref_mem[alu] = din;
      end else begin
        e.data = (lat == 0) ? '0 : ref_rd(alu);
        e.we   = rw && (lat != 0);
      end
      exp_occ = (lat == 0) ? 1 + TIMEOUT : 1 + lat;
    end else begin
      exp_occ = 1;
    end
    wb_q.push_back(e);

    in_valid = v; mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    alu_result_in = alu; dataIn_in = din; dstReg_in = dst;

    occ = 0;
    forever begin
      @(negedge clk);
      occ++;
      if (!stall) break;
      if (occ >= 20) begin
        errors++;
        $display("FAIL occupancy_bound: stall still high after %0d cycles", occ);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stall never released");
      end
    end
    check("occupancy", occ, exp_occ);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    alu_result_in = '0; dataIn_in = '0; dstReg_in = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   mem_bus.mem_req,   1'b0);
    check({tag, "_mem_we"},    mem_bus.mem_we,    1'b0);
    check({tag, "_mem_addr"},  mem_bus.mem_addr,  '0);
    check({tag, "_mem_wdata"}, mem_bus.mem_wdata, '0);
    check({tag, "_stall"},     stall,             1'b0);
    check({tag, "_wb_data"},   wb_data,           '0);
    check({tag, "_wb_dst"},    wb_dstReg,         '0);
    check({tag, "_wb_rw"},     wb_reg_write,      1'b0);
    check({tag, "_mem_err"},   mem_err,           1'b0);
  endtask

  // Writeback monitor: a cycle with stall low retires into MEM/WB at the next edge.
  initial begin
    wb_exp_t e;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected_retire", 1'b1, 1'b0);
          end else begin
            e = wb_q.pop_front();
            check("wb_reg_write", wb_reg_write, e.we);
            if (e.we) begin
              check("wb_data", wb_data, e.data);
              check("wb_dstReg", wb_dstReg, e.dst);
            end
          end
        end
        pend = !stall;
      end
    end
  end

  // Memory responder: checks each request against the issued op and answers
  // on the requested BUSY cycle; ready noise while idle must be ignored.
  initial begin
    bus_exp_t cur;
    bit active = 1'b0;
    int cnt = 0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        mem_bus.mem_ready = 1'b0;
      end else if (mem_bus.mem_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected_req", 1'b1, 1'b0);
            cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.lat = 1;
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1'b1;
          cnt = 0;
        end
        cnt++;
        check("mem_addr", mem_bus.mem_addr, cur.addr);
        check("mem_we", mem_bus.mem_we, cur.we);
        if (cur.we) check("mem_wdata", mem_bus.mem_wdata, cur.wdata);
        if (cur.lat != 0 && cnt == cur.lat) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = cur.we ? DATA_W'($urandom) : arr_rd(cur.addr);
          if (cur.we) mem_array[cur.addr] = cur.wdata;
        end else begin
          mem_bus.mem_ready = 1'b0;
          mem_bus.mem_rdata = DATA_W'($urandom);
        end
      end else begin
        if (active) begin
          check("mem_req_cycles", cnt, (cur.lat == 0) ? TIMEOUT : cur.lat);
          active = 1'b0;
        end
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = DATA_W'($urandom);
      end
    end
  end

  // Stimulus.
  initial begin
    int kind;
    logic [DATA_W-1:0] a;
    clear_inputs();

    // Power-on reset.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // ALU op passes in one cycle.
    issue(1, 0, 0, 1, 16'h1234, 16'h0, 4'd5, 0);

    // Load, ready on the 3rd BUSY cycle, then an ALU op right behind it.
    ref_mem[16'h0040]   = 16'hBEEF;
    mem_array[16'h0040] = 16'hBEEF;
    issue(1, 1, 0, 1, 16'h0040, 16'h0, 4'd3, 3);
    issue(1, 0, 0, 1, 16'h5678, 16'h0, 4'd7, 0);

    // Store with immediate ready, then read it back.
    issue(1, 0, 1, 0, 16'h0010, 16'hA5A5, 4'd2, 1);
    issue(1, 1, 0, 1, 16'h0010, 16'h0, 4'd9, 2);

    // Both mem bits set behaves as a store without register write.
    issue(1, 1, 1, 1, 16'h0012, 16'h3C3C, 4'd4, 2);
    issue(1, 1, 0, 1, 16'h0012, 16'h0, 4'd6, 1);

    // Randomized instruction mix over a small address window.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      a    = DATA_W'($urandom_range(0, 7) * 2);
      case (kind)
        0:       issue(0, 1'($urandom), 1'($urandom), 1'($urandom), DATA_W'($urandom),
                       DATA_W'($urandom), REG_W'($urandom), 1);
        1, 2, 3: issue(1, 0, 0, 1'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                       REG_W'($urandom), 0);
        4, 5, 6: issue(1, 1, 0, 1'($urandom_range(0, 3) != 0), a, DATA_W'($urandom),
                       REG_W'($urandom), $urandom_range(1, TIMEOUT - 1));
        7, 8:    issue(1, 0, 1, 1'($urandom), a, DATA_W'($urandom), REG_W'($urandom),
                       $urandom_range(1, TIMEOUT - 1));
        default: issue(1, 1, 1, 1'($urandom), a, DATA_W'($urandom), REG_W'($urandom),
                       $urandom_range(1, TIMEOUT - 1));
      endcase
    end
    check("mem_err_before_timeout", mem_err, 1'b0);

    // Timeout: a load that never gets ready.
    issue(1, 1, 0, 1, 16'h0040, 16'h0, 4'd8, 0);
    check("mem_err_set", mem_err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 1, DATA_W'($urandom), 16'h0, REG_W'(i + 1), 0);
    end
    check("mem_err_sticky", mem_err, 1'b1);

    // Reset in the middle of an access: bus drops at once, all state clears.
    in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
    alu_result_in = 16'h0020; dataIn_in = 16'h0; dstReg_in = 4'd1;
    bus_q.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0, lat: 0});
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_reset", mem_bus.mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_reset_outputs("midbusy");
    wb_q.delete();
    bus_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal operation resumes after release.
    issue(1, 0, 0, 1, 16'hCAFE, 16'h0, 4'd12, 0);
    issue(1, 1, 0, 1, 16'h0010, 16'h0, 4'd13, 2);
    issue(0, 0, 0, 0, 16'h0, 16'h0, 4'd0, 0);

    @(negedge clk);
    #1;
    check("wb_queue_drained", wb_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
